// File: rtl/ddf_pkg.sv
// ddf_pkg: shared definitions for the round-robin accumulator scheduler.
//   state_t / IDLE..OUT : scheduler FSM encoding (3-bit)
//   clog2()             : ceiling log2, used to size flow ids
package ddf_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t HDR   = 3'd1;
    localparam state_t FETCH = 3'd2;
    localparam state_t ACC   = 3'd3;
    localparam state_t OUT   = 3'd4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ddf_rr_arbiter.sv
// ddf_rr_arbiter: round-robin pointer plus combinational search.
//   ck_i, rst_i   : clock, synchronous active-high reset
//   req_i         : per-flow request (header FIFO not empty)
//   upd_i         : a grant was taken this cycle; pointer moves to upd_id_i
//   upd_id_i      : flow that was granted
//   gnt_valid_o   : some flow requests
//   gnt_id_o      : first requesting flow after the pointer, with wrap
module ddf_rr_arbiter
    import ddf_pkg::*;
#(
    parameter int NFLOW = 2,
    parameter int FID_W = clog2(NFLOW)
) (
    input  logic             ck_i,
    input  logic             rst_i,
    input  logic [NFLOW-1:0] req_i,
    input  logic             upd_i,
    input  logic [FID_W-1:0] upd_id_i,
    output logic             gnt_valid_o,
    output logic [FID_W-1:0] gnt_id_o
);

    logic [FID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = upd_i ? upd_id_i : rr_ptr_q;

    // Pointer starts at the last flow so flow 0 is searched first.
    always_ff @(posedge ck_i) begin
        if (rst_i) rr_ptr_q <= FID_W'(NFLOW - 1);
        else       rr_ptr_q <= rr_ptr_d;
    end

    // Walk offsets from farthest to nearest so the nearest requester after
    // the pointer is the one left standing. The pointer is always < NFLOW,
    // so a single subtract is enough to wrap.
    always_comb begin
        int               idx;
        logic [FID_W-1:0] idx_w;
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        idx         = 0;
        idx_w       = '0;
        for (int k = NFLOW; k >= 1; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NFLOW) idx = idx - NFLOW;
            idx_w = idx[FID_W-1:0];
            if (req_i[idx_w]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/ddf_rr_acc_scheduler.sv
// ddf_rr_acc_scheduler: packet-granular round-robin scheduler feeding one
// shared accumulator. A granted flow keeps the grant for its whole packet;
// the packet's words are summed and {flow_id, sum} is written out.
//   ck_i, rst_i   : clock, synchronous active-high reset
//   nda_data_i    : per-flow packet length words, flow i at [i*WIDTH_NDA +: WIDTH_NDA]
//   nda_empty_i   : per-flow length FIFO empty
//   nda_read_o    : per-flow length FIFO read strobe (one-hot or 0)
//   in_data_i     : per-flow data words, flow i at [i*WIDTH +: WIDTH]
//   in_empty_i    : per-flow data FIFO empty
//   in_read_o     : per-flow data FIFO read strobe (one-hot or 0)
//   full_i        : output FIFO full
//   wr_o          : output FIFO write strobe
//   out_data_o    : {flow_id, sum}, straight from registers
//   busy_o        : FSM not idle
module ddf_rr_acc_scheduler
    import ddf_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WIDTH_NDA = 4,
    parameter int NFLOW     = 2,
    parameter int FID_W     = 1
) (
    input  logic                       ck_i,
    input  logic                       rst_i,
    input  logic [NFLOW*WIDTH_NDA-1:0] nda_data_i,
    input  logic [NFLOW-1:0]           nda_empty_i,
    output logic [NFLOW-1:0]           nda_read_o,
    input  logic [NFLOW*WIDTH-1:0]     in_data_i,
    input  logic [NFLOW-1:0]           in_empty_i,
    output logic [NFLOW-1:0]           in_read_o,
    input  logic                       full_i,
    output logic                       wr_o,
    output logic [FID_W+WIDTH-1:0]     out_data_o,
    output logic                       busy_o
);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH_NDA-1:0]   rem_q, rem_d;
    logic [FID_W-1:0]       gnt_q, gnt_d;

    logic                   arb_valid;
    logic [FID_W-1:0]       arb_id;
    logic                   take;

    logic [WIDTH_NDA-1:0]   nda_w [NFLOW];
    logic [WIDTH-1:0]       in_w  [NFLOW];
    logic [WIDTH_NDA-1:0]   nda_len;
    logic [WIDTH-1:0]       in_word;
    logic                   in_avail;

    for (genvar i = 0; i < NFLOW; i++) begin : g_slice
        assign nda_w[i] = nda_data_i[i*WIDTH_NDA +: WIDTH_NDA];
        assign in_w[i]  = in_data_i[i*WIDTH +: WIDTH];
    end

    assign nda_len  = nda_w[gnt_q];
    assign in_word  = in_w[gnt_q];
    assign in_avail = !in_empty_i[gnt_q];

    // The pointer only moves when a header is actually read.
    assign take = (state_q == IDLE) && arb_valid && !rst_i;

    ddf_rr_arbiter #(.NFLOW(NFLOW), .FID_W(FID_W)) u_arb (
        .ck_i        (ck_i),
        .rst_i       (rst_i),
        .req_i       (~nda_empty_i),
        .upd_i       (take),
        .upd_id_i    (arb_id),
        .gnt_valid_o (arb_valid),
        .gnt_id_o    (arb_id)
    );

    // State register
    always_ff @(posedge ck_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = HDR;
            HDR: begin
                if (nda_len == '0)  state_d = IDLE;   // empty packet dropped
                else if (in_avail)  state_d = ACC;
                else                state_d = FETCH;
            end
            FETCH:   if (in_avail) state_d = ACC;
            ACC: begin
                if (rem_q == WIDTH_NDA'(1)) state_d = OUT;
                else if (!in_avail)         state_d = FETCH;
            end
            OUT:     if (!full_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state; a word read in HDR/FETCH/ACC lands here in ACC.
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        gnt_d = gnt_q;
        case (state_q)
            IDLE: if (arb_valid) begin
                gnt_d = arb_id;
                acc_d = '0;
            end
            HDR:  rem_d = nda_len;
            ACC: begin
                acc_d = acc_q + in_word;
                rem_d = rem_q - WIDTH_NDA'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            acc_q <= '0;
            rem_q <= '0;
            gnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            gnt_q <= gnt_d;
        end
    end

    // Strobes; held off during reset so no FIFO word is consumed and lost.
    always_comb begin
        nda_read_o = '0;
        in_read_o  = '0;
        wr_o       = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE:  if (arb_valid) nda_read_o = NFLOW'(1) << arb_id;
                HDR:   if (nda_len != '0 && in_avail) in_read_o = NFLOW'(1) << gnt_q;
                FETCH: if (in_avail) in_read_o = NFLOW'(1) << gnt_q;
                ACC:   if (rem_q != WIDTH_NDA'(1) && in_avail) in_read_o = NFLOW'(1) << gnt_q;
                OUT:   wr_o = !full_i;
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign out_data_o = {gnt_q, acc_q};

endmodule

// File: tb/tb_ddf_rr_acc_scheduler.sv
module tb_ddf_rr_acc_scheduler;

    localparam int W  = 8;
    localparam int ND = 4;
    localparam int NF = 4;
    localparam int FW = 2;

    logic              ck = 1'b0;
    logic              rst_i = 1'b1;
    logic [NF*ND-1:0]  nda_data_i = '0;
    logic [NF-1:0]     nda_empty_i = '1;
    logic [NF-1:0]     nda_read_o;
    logic [NF*W-1:0]   in_data_i = '0;
    logic [NF-1:0]     in_empty_i = '1;
    logic [NF-1:0]     in_read_o;
    logic              full_i = 1'b0;
    logic              wr_o;
    logic [FW+W-1:0]   out_data_o;
    logic              busy_o;

    ddf_rr_acc_scheduler #(.WIDTH(W), .WIDTH_NDA(ND), .NFLOW(NF), .FID_W(FW)) dut (
        .ck_i        (ck),
        .rst_i       (rst_i),
        .nda_data_i  (nda_data_i),
        .nda_empty_i (nda_empty_i),
        .nda_read_o  (nda_read_o),
        .in_data_i   (in_data_i),
        .in_empty_i  (in_empty_i),
        .in_read_o   (in_read_o),
        .full_i      (full_i),
        .wr_o        (wr_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    always #5 ck = ~ck;

    // FIFO models: queue contents plus the registered output word.
    logic [ND-1:0]   nda_q [NF][$];
    logic [W-1:0]    dat_q [NF][$];
    logic [ND-1:0]   nda_reg [NF];
    logic [W-1:0]    dat_reg [NF];
    logic [NF-1:0]   nda_hold = '0;
    logic [NF-1:0]   in_hold  = '0;
    logic [FW+W-1:0] exp_q [NF][$];
    int              glog[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_hdr = 0, t_wr = 0, nwr = 0;
    int rd_cnt [NF];
    logic [NF-1:0] watch_mask = '0;
    int other_rd = 0;
    bit soak = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_inputs();
        for (int f = 0; f < NF; f++) begin
            nda_empty_i[f] = (nda_q[f].size() == 0) || nda_hold[f];
            in_empty_i[f]  = (dat_q[f].size() == 0) || in_hold[f];
            nda_data_i[f*ND +: ND] = nda_reg[f];
            in_data_i[f*W +: W]    = dat_reg[f];
        end
    endtask

    task automatic push_hdr(input int f, input logic [ND-1:0] len, input logic [W-1:0] sum);
        nda_q[f].push_back(len);
        if (len != 0) exp_q[f].push_back({FW'(f), sum});
        update_inputs();
    endtask

    task automatic push_word(input int f, input logic [W-1:0] w);
        dat_q[f].push_back(w);
        update_inputs();
    endtask

    // One clock: sample outputs at negedge, model FIFO pops just after posedge.
    task automatic step();
        logic [NF-1:0]   rn, ri;
        logic            w;
        logic [FW+W-1:0] od, ex;
        int              fid;
        @(negedge ck);
        rn = nda_read_o; ri = in_read_o; w = wr_o; od = out_data_o;
        if (rn != 0 || ri != 0) begin
            chk("rd_nda_while_empty", rn & nda_empty_i, 0);
            chk("rd_in_while_empty", ri & in_empty_i, 0);
            chk("rd_onehot", {31'd0, $onehot0(rn)} + {31'd0, $onehot0(ri)} + {31'd0, $onehot0(rn | ri)}, 3);
        end
        if (((rn | ri) & watch_mask) != 0) other_rd++;
        for (int f = 0; f < NF; f++) begin
            if (rn[f]) begin glog.push_back(f); t_hdr = cyc; end
            if (ri[f]) rd_cnt[f]++;
        end
        if (w) begin
            chk("wr_while_full", full_i, 0);
            t_wr = cyc;
            nwr++;
            fid = int'(od[FW+W-1:W]);
            ex = (exp_q[fid].size() > 0) ? exp_q[fid].pop_front() : 'x;
            chk("sb_out_data", od, ex);
        end
        @(posedge ck);
        #1;
        cyc++;
        for (int f = 0; f < NF; f++) begin
            if (rn[f] && nda_q[f].size() > 0) nda_reg[f] = nda_q[f].pop_front();
            if (ri[f] && dat_q[f].size() > 0) dat_reg[f] = dat_q[f].pop_front();
        end
        if (soak) begin
            full_i   = ($urandom_range(0, 3) == 0);
            in_hold  = NF'($urandom_range(0, 15)) & NF'($urandom_range(0, 15));
            nda_hold = NF'($urandom_range(0, 15)) & NF'($urandom_range(0, 15));
        end
        update_inputs();
    endtask

    function automatic bit all_idle();
        bit d;
        d = !busy_o;
        for (int f = 0; f < NF; f++)
            if (exp_q[f].size() != 0 || nda_q[f].size() != 0 || dat_q[f].size() != 0) d = 0;
        return d;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = all_idle();
        end
        chk(tag, done, 1);
    endtask

    task automatic flush_all();
        for (int f = 0; f < NF; f++) begin
            nda_q[f].delete(); dat_q[f].delete(); exp_q[f].delete();
        end
        update_inputs();
    endtask

    initial begin
        int n0;
        logic [W-1:0] s, d;
        int f, len;
        for (int i = 0; i < NF; i++) begin
            nda_reg[i] = '0; dat_reg[i] = '0; rd_cnt[i] = 0;
        end
        update_inputs();

        // Reset state
        rst_i = 1'b1;
        step(); step();
        chk("rst_busy", busy_o, 0);
        chk("rst_wr", wr_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_strobes", {nda_read_o, in_read_o}, 0);
        rst_i = 1'b0;

        // Single packet: 5+6+7 = 18; wr lands in the 6th cycle counting the
        // nda_read cycle as the first (5 edges later).
        push_hdr(0, 3, 8'd18);
        push_word(0, 5); push_word(0, 6); push_word(0, 7);
        drain("single_drain", 50);
        chk("single_latency", t_wr - t_hdr, 5);
        chk("single_nwr", nwr, 1);

        // Round robin from a fresh reset: 0,1,0,1,0,1
        rst_i = 1'b1; step(); rst_i = 1'b0;
        glog.delete();
        for (int i = 0; i < 3; i++) begin
            push_hdr(0, 1, 8'(10 + i)); push_word(0, 8'(10 + i));
            push_hdr(1, 1, 8'(20 + i)); push_word(1, 8'(20 + i));
        end
        drain("rr_drain", 100);
        chk("rr_count", glog.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("rr_order", (i < glog.size()) ? glog[i] : -1, i % 2);

        // Output full stall in OUT: wr held low, out_data frozen at {2,3}
        full_i = 1'b1;
        push_hdr(2, 2, 8'd3); push_word(2, 1); push_word(2, 2);
        n0 = nwr;
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("full_wr", wr_o, 0);
            chk("full_out_data", out_data_o, {2'd2, 8'd3});
            chk("full_busy", busy_o, 1);
            step();
        end
        chk("full_no_wr", nwr - n0, 0);
        full_i = 1'b0;
        drain("full_drain", 50);

        // Data starvation mid-packet: FETCH holds, other flow untouched
        push_hdr(1, 3, 8'd60); push_word(1, 10);
        step(); step();
        push_hdr(0, 1, 8'd9); push_word(0, 9);
        watch_mask = 4'b1101;
        other_rd = 0;
        for (int i = 0; i < 6; i++) step();
        chk("fetch_other_reads", other_rd, 0);
        chk("fetch_busy", busy_o, 1);
        watch_mask = '0;
        push_word(1, 20); push_word(1, 30);
        drain("fetch_drain", 50);

        // Zero-length packet on flow 2 is dropped, flow 3 served next
        glog.delete();
        n0 = nwr;
        push_hdr(2, 0, 8'd0);
        push_hdr(3, 1, 8'd4); push_word(3, 4);
        drain("zero_drain", 50);
        chk("zero_nwr", nwr - n0, 1);
        chk("zero_g0", (glog.size() > 0) ? glog[0] : -1, 2);
        chk("zero_g1", (glog.size() > 1) ? glog[1] : -1, 3);

        // Wrap: 200+100 mod 256 = 44
        push_hdr(0, 2, 8'd44); push_word(0, 200); push_word(0, 100);
        drain("wrap_drain", 50);

        // Reset while in ACC
        for (int i = 0; i < NF; i++) rd_cnt[i] = 0;
        push_hdr(1, 4, 8'd10);
        for (int i = 1; i <= 4; i++) push_word(1, 8'(i));
        n0 = 0;
        while (rd_cnt[1] < 2 && n0 < 20) begin step(); n0++; end
        chk("acc_reached", rd_cnt[1] >= 2, 1);
        chk("acc_busy", busy_o, 1);
        rst_i = 1'b1;
        step();
        chk("midrst_busy", busy_o, 0);
        chk("midrst_strobes", {nda_read_o, in_read_o, wr_o}, 0);
        flush_all();
        glog.delete();
        for (int i = 0; i < NF; i++) begin
            push_hdr(i, 1, 8'(i + 1)); push_word(i, 8'(i + 1));
        end
        rst_i = 1'b0;
        drain("midrst_drain", 100);
        for (int i = 0; i < NF; i++)
            chk("midrst_order", (i < glog.size()) ? glog[i] : -1, i);

        // Random soak: random lengths (first one max), holds and full
        for (int p = 0; p < 40; p++) begin
            f = $urandom_range(0, NF - 1);
            len = (p == 0) ? 15 : $urandom_range(0, 15);
            s = '0;
            for (int k = 0; k < len; k++) begin
                d = 8'($urandom_range(0, 255));
                s = s + d;
                dat_q[f].push_back(d);
            end
            push_hdr(f, ND'(len), s);
        end
        soak = 1;
        for (int i = 0; i < 3000; i++) step();
        soak = 0;
        full_i = 1'b0; in_hold = '0; nda_hold = '0;
        update_inputs();
        drain("soak_drain", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
